// File: rtl/mmap_loader_if.sv
// rtl/mmap_loader_if.sv - payload stream and shared-BRAM port bundle for mmap_loader
interface mmap_loader_if #(
  parameter int AW = 10
);
  logic          i_valid;
  logic [31:0]   i_data;
  logic          o_ready;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [31:0]   o_wdata;
  logic [AW-1:0] o_raddr;
  logic [31:0]   i_rdata;

  modport slave (
    input  i_valid, i_data, i_rdata,
    output o_ready, o_we, o_waddr, o_wdata, o_raddr
  );

  modport master (
    output i_valid, i_data, i_rdata,
    input  o_ready, o_we, o_waddr, o_wdata, o_raddr
  );
endinterface

// File: rtl/mmap_loader.sv
// rtl/mmap_loader.sv - loads a payload into shared BRAM, kicks the engine, polls for completion
module mmap_loader #(
  parameter int AW        = 10,
  parameter int NWORDS    = 7,
  parameter int DONE_ADDR = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mmap_loader_if.slave  bus,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_timeout
);
  localparam int CW = $clog2(NWORDS + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_POLL  = 3'd2;
  localparam logic [2:0] S_CLR0  = 3'd3;
  localparam logic [2:0] S_CLR1  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [AW-1:0] DONE_A = AW'(DONE_ADDR);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ok_q, ok_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          unused_rdata;

  assign unused_rdata = ^bus.i_rdata[31:1];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    ok_d    = ok_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      S_LOAD: begin
        ready_d = 1'b1;
        if (bus.i_valid && ready_q) begin
          we_d    = 1'b1;
          waddr_d = AW'(count_q) + AW'(1);
          wdata_d = bus.i_data;
          count_d = count_q + CW'(1);
          if (count_q == CW'(NWORDS - 1)) begin
            ready_d = 1'b0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        we_d    = 1'b1;
        waddr_d = '0;
        wdata_d = 32'h1;
        timer_d = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        // timer==0 marks the first poll cycle, whose read predates the start write
        if (timer_q != '0 && bus.i_rdata[0]) begin
          ok_d    = 1'b1;
          state_d = S_CLR0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          ok_d    = 1'b0;
          state_d = S_CLR0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CLR0: begin
        we_d    = 1'b1;
        waddr_d = '0;
        wdata_d = 32'h0;
        state_d = S_CLR1;
      end
      S_CLR1: begin
        we_d    = 1'b1;
        waddr_d = DONE_A;
        wdata_d = 32'h0;
        state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = ok_q;
        to_d    = ~ok_q;
        ready_d = 1'b1;
        count_d = '0;
        state_d = S_LOAD;
      end
      default: begin
        ready_d = 1'b1;
        count_d = '0;
        state_d = S_LOAD;
      end
    endcase
    busy_d = (state_d != S_LOAD) || (count_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_LOAD;
      count_q <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_we    = we_q;
  assign bus.o_waddr = waddr_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_raddr = DONE_A;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = to_q;
endmodule

// File: tb/tb_mmap_loader.sv
// tb/tb_mmap_loader.sv - self-checking bench for mmap_loader with a BRAM/engine model
module tb_mmap_loader;
  localparam int AW        = 10;
  localparam int NWORDS    = 7;
  localparam int DONE_ADDR = 8;
  localparam int TIMEOUT   = 16;

  typedef struct {
    int mode;       // 0 back-to-back, 1 toggled valid, 2 random gaps + random data
    int delay;      // engine finish delay after start write commits; 0 = never
    bit preload;    // DONE word forced to 1 before the job
    int exp_polls;
    bit exp_done;
    int exp_span;   // 0 = derive from the handshake stamps
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  logic i_clk = 1'b0;
  logic i_rst;
  logic o_busy, o_done, o_timeout;

  mmap_loader_if #(.AW(AW)) bus ();

  mmap_loader #(.AW(AW), .NWORDS(NWORDS), .DONE_ADDR(DONE_ADDR), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .bus      (bus.slave),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // BRAM flag word plus a minimal engine: start write clears DONE, then sets it after eng_delay edges
  logic [31:0] flag_word = 32'h0;
  logic        preload   = 1'b0;
  int          eng_delay = 0;
  int          eng_cnt   = 0;
  bit          eng_armed = 1'b0;

  always @(posedge i_clk) begin : bram_model
    logic [31:0] nx;
    logic        start_wr;
    start_wr = bus.o_we && bus.o_waddr == AW'(0) && bus.o_wdata[0];
    nx = flag_word;
    if (preload) nx = 32'h1;
    if (bus.o_we && bus.o_waddr == AW'(DONE_ADDR)) nx = bus.o_wdata;
    if (start_wr) nx = 32'h0;
    if (eng_armed && eng_cnt == eng_delay) nx = 32'h1;
    flag_word   <= nx;
    bus.i_rdata <= nx;
    if (start_wr) begin
      eng_armed <= (eng_delay != 0);
      eng_cnt   <= 1;
    end else if (eng_armed) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == eng_delay) eng_armed <= 1'b0;
    end
  end

  wr_t obs[$];
  int  n_done = 0, n_to = 0, n_both = 0;

  always @(negedge i_clk) begin
    if (bus.o_we) obs.push_back('{bus.o_waddr, bus.o_wdata, cyc});
    if (o_done) n_done <= n_done + 1;
    if (o_timeout) n_to <= n_to + 1;
    if (o_done && o_timeout) n_both <= n_both + 1;
  end

  int nvec = 0, nerr = 0;
  logic [31:0] words [NWORDS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_done(input int d);
    // rdata shows the flag one cycle after it is set; the last usable poll has index TIMEOUT-1
    return d >= 1 && d + 1 <= TIMEOUT - 1;
  endfunction

  function automatic int ref_polls(input int d);
    return ref_done(d) ? d + 2 : TIMEOUT;
  endfunction

  task automatic drive_words(input int mode, input int nw, output int first_hs, output int last_hs);
    first_hs = -1;
    last_hs  = -1;
    for (int i = 0; i < nw; i++) begin
      int gap;
      bit hs;
      int guard;
      gap = (mode == 1 && i > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) begin
        bus.i_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      bus.i_valid = 1'b1;
      bus.i_data  = words[i];
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 50) begin
        hs = bus.o_ready;
        if (hs) begin
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        @(posedge i_clk); #1;
        guard++;
      end
      if (!hs) chk("handshake_wait", 64'd0, 64'd1);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int base, dbase, tbase, bbase, first_hs, last_hs, guard, span;
    wr_t exp_q[$];
    for (int i = 0; i < NWORDS; i++)
      words[i] = (v.mode == 2) ? $urandom : {16'(2 * i + 1), 16'(2 * i + 2)};
    eng_delay = v.delay;
    if (v.preload) begin
      preload = 1'b1;
      @(posedge i_clk); #1;
      preload = 1'b0;
    end
    base = obs.size(); dbase = n_done; tbase = n_to; bbase = n_both;
    drive_words(v.mode, NWORDS, first_hs, last_hs);
    chk("ready_drop", 64'(bus.o_ready), 64'd0);
    chk("busy_mid", 64'(o_busy), 64'd1);
    guard = 0;
    while (n_done == dbase && n_to == tbase && guard < 200) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard >= 200) chk("pulse_wait", 64'd0, 64'd1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("done_pulses", 64'(n_done - dbase), 64'(v.exp_done));
    chk("timeout_pulses", 64'(n_to - tbase), 64'(!v.exp_done));
    chk("both_pulses", 64'(n_both - bbase), 64'd0);
    chk("ready_after", 64'(bus.o_ready), 64'd1);
    chk("busy_after", 64'(o_busy), 64'd0);

    for (int i = 0; i < NWORDS; i++) exp_q.push_back('{AW'(i + 1), words[i], 0});
    exp_q.push_back('{AW'(0), 32'h1, 0});
    exp_q.push_back('{AW'(0), 32'h0, 0});
    exp_q.push_back('{AW'(DONE_ADDR), 32'h0, 0});
    chk("write_count", 64'(obs.size() - base), 64'(NWORDS + 3));
    if (obs.size() - base >= NWORDS + 3) begin
      for (int j = 0; j < NWORDS + 3; j++)
        chk("write_addr_data", {obs[base + j].a, obs[base + j].d}, {exp_q[j].a, exp_q[j].d});
      span = obs[base + NWORDS - 1].c - obs[base].c + 1;
      chk("payload_span", 64'(span), 64'(v.exp_span != 0 ? v.exp_span : last_hs - first_hs + 1));
      chk("first_write_latency", 64'(obs[base].c), 64'(first_hs + 1));
      chk("poll_cycles", 64'(obs[base + NWORDS + 1].c - obs[base + NWORDS].c - 1), 64'(v.exp_polls));
    end
  endtask

  vec_t tbl[6];

  initial begin
    int fh, lh;
    tbl[0] = '{0, 10, 1'b0, 12, 1'b1, 7};
    tbl[1] = '{1, 3,  1'b0, 5,  1'b1, 13};
    tbl[2] = '{0, 0,  1'b0, 16, 1'b0, 7};
    tbl[3] = '{0, 14, 1'b0, 16, 1'b1, 7};
    tbl[4] = '{0, 0,  1'b1, 16, 1'b0, 7};
    tbl[5] = '{1, 1,  1'b0, 3,  1'b1, 13};

    i_rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("reset_flags", {59'd0, bus.o_we, bus.o_ready, o_busy, o_done, o_timeout}, 64'b01000);
    chk("reset_raddr", 64'(bus.o_raddr), 64'(DONE_ADDR));
    chk("reset_waddr_wdata", {bus.o_waddr, bus.o_wdata}, 64'd0);

    for (int k = 0; k < 6; k++) run_job(tbl[k]);

    // reset asserted while word 4 is on the bus
    for (int i = 0; i < NWORDS; i++) words[i] = {16'(2 * i + 1), 16'(2 * i + 2)};
    eng_delay = 0;
    drive_words(0, 3, fh, lh);
    bus.i_valid = 1'b1;
    bus.i_data  = words[3];
    #2 i_rst = 1'b1;
    #1;
    chk("midjob_reset_flags", {59'd0, bus.o_we, bus.o_ready, o_busy, o_done, o_timeout}, 64'b01000);
    chk("midjob_reset_raddr", 64'(bus.o_raddr), 64'(DONE_ADDR));
    chk("midjob_reset_waddr_wdata", {bus.o_waddr, bus.o_wdata}, 64'd0);
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    run_job('{0, 5, 1'b0, 7, 1'b1, 7});

    for (int k = 0; k < 4; k++) begin
      vec_t v;
      v.mode      = 2;
      v.delay     = int'($urandom_range(0, 17));
      v.preload   = ($urandom_range(0, 1) == 1);
      v.exp_polls = ref_polls(v.delay);
      v.exp_done  = ref_done(v.delay);
      v.exp_span  = 0;
      run_job(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
